// File: rtl/config_loader.sv
// config_loader: drives the head of the configuration shift chain, serializing host words MSB-first; optional CRC readback when CONFIG_READBACK_EN is defined.
// Latency: CHAIN_LENGTH + ceil(CHAIN_LENGTH/WORD_WIDTH) cycles FETCH+SHIFT, + CHAIN_LENGTH cycles VERIFY (readback builds only), + 1 cycle DONE.
// Backpressure: word_ready only in FETCH (one bubble per word); while the host stalls, config_en stays low so the chain holds.
module config_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 64,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  config_clk,
   input  logic                  config_rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_out,
   output logic                  config_en,
   input  logic                  chain_return,
   output logic                  busy,
   output logic                  done,
   output logic                  verify_fail
);

   localparam int                   WB_W     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [WB_W-1:0]      LAST_WB  = WB_W'(WORD_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LENGTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} state_t;

   state_t                state, state_nxt;
   logic [WORD_WIDTH-1:0] shift_reg;
   logic [WB_W-1:0]       word_cnt;
   logic [CNT_WIDTH-1:0]  bit_cnt;

`ifdef CONFIG_READBACK_EN
   logic [7:0]            load_crc;
   logic [7:0]            ret_crc;
   logic [7:0]            ret_crc_nxt;
   logic [CNT_WIDTH-1:0]  vfy_cnt;

   // CRC-8, polynomial x^8+x^2+x+1, one bit per call, MSB-first feed
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   assign ret_crc_nxt = crc8_step(ret_crc, chain_return);
`endif

   // State register
   always_ff @(posedge config_clk or posedge config_rst) begin
      if (config_rst) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next-state and output decode; all outputs come from registered state
   always_comb begin
      state_nxt  = state;
      word_ready = 1'b0;
      config_en  = 1'b0;
      config_out = 1'b0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            word_ready = 1'b1;
            if (word_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            config_en  = 1'b1;
            config_out = shift_reg[WORD_WIDTH-1];
            // The chain length wins over the word boundary: leftover LSBs of the last word are dropped
            if (bit_cnt == LAST_BIT) begin
`ifdef CONFIG_READBACK_EN
               state_nxt = VERIFY;
`else
               state_nxt = DONE;
`endif
            end else if (word_cnt == LAST_WB) begin
               state_nxt = FETCH;
            end
         end
`ifdef CONFIG_READBACK_EN
         VERIFY: begin
            // Recirculate the tail back into the head so one full pass leaves the chain unchanged
            config_en  = 1'b1;
            config_out = chain_return;
            if (vfy_cnt == LAST_BIT) state_nxt = DONE;
         end
`endif
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Word shift register and bit counters
   always_ff @(posedge config_clk or posedge config_rst) begin
      if (config_rst) begin
         shift_reg <= '0;
         word_cnt  <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bit_cnt  <= '0;
                  word_cnt <= '0;
               end
            end
            FETCH: begin
               if (word_valid) begin
                  shift_reg <= word_in;
                  word_cnt  <= '0;
               end
            end
            SHIFT: begin
               shift_reg <= shift_reg << 1;
               word_cnt  <= word_cnt + WB_W'(1);
               bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef CONFIG_READBACK_EN
   // CRCs of the loaded and returned streams; verify_fail is sticky until the next accepted start
   always_ff @(posedge config_clk or posedge config_rst) begin
      if (config_rst) begin
         load_crc    <= '0;
         ret_crc     <= '0;
         vfy_cnt     <= '0;
         verify_fail <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  load_crc    <= '0;
                  ret_crc     <= '0;
                  vfy_cnt     <= '0;
                  verify_fail <= 1'b0;
               end
            end
            SHIFT: begin
               load_crc <= crc8_step(load_crc, shift_reg[WORD_WIDTH-1]);
            end
            VERIFY: begin
               ret_crc <= ret_crc_nxt;
               vfy_cnt <= vfy_cnt + CNT_WIDTH'(1);
               // Compare using the CRC that includes this final returned bit
               if (vfy_cnt == LAST_BIT) verify_fail <= (ret_crc_nxt != load_crc);
            end
            default: ;
         endcase
      end
   end
`else
   logic unused_chain_return;
   assign unused_chain_return = chain_return;
   assign verify_fail         = 1'b0;
`endif

endmodule
